serial_gate_sequencer: RTL

//   Bit-serial controller that time-shares ONE 1-bit logic unit, built only from

---
 rtl/serial_gate_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_gate_sequencer.sv
// Bit-serial op engine: one shared nand-built 1-bit unit evaluates a WIDTH-bit operand pair LSB first.
// Latency: start sampled at edge k -> busy for WIDTH cycles -> done_o pulse one cycle; back-to-back every WIDTH+1.
// No backpressure: start_i is only accepted in IDLE/DONE and is ignored in RUN; optional macro SERIAL_GATE_XOR_EN enables ops 4/5.
module serial_gate_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] y_o,
   output logic             err_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r;
   logic [2:0]       op_r;
   logic [WIDTH-2:0] sr;        // bits already evaluated; the current bit completes the word
   logic [WIDTH-1:0] full;      // current bit on top of the accumulated bits
   logic             load, last;
   logic             abit, bbit, ubit, illegal;

   assign abit = a_r[cnt];
   assign bbit = b_r[cnt];
   assign last = (cnt == LAST);
   assign full = {ubit, sr};

   // Shared 1-bit unit: only nand primitives
   logic n_ab, and_o, n_a, n_b, or_o, nor_o;
   nand g_nab (n_ab,  abit, bbit);
   nand g_and (and_o, n_ab, n_ab);
   nand g_na  (n_a,   abit, abit);
   nand g_nb  (n_b,   bbit, bbit);
   nand g_or  (or_o,  n_a,  n_b);
   nand g_nor (nor_o, or_o, or_o);
`ifdef SERIAL_GATE_XOR_EN
   logic x_1, x_2, xor_o, xnor_o;
   nand g_x1  (x_1,    abit, n_ab);
   nand g_x2  (x_2,    bbit, n_ab);
   nand g_xor (xor_o,  x_1,  x_2);
   nand g_xnr (xnor_o, xor_o, xor_o);
`endif

   // Select the unit output for the latched op and flag unsupported ops
   always_comb begin
      ubit    = 1'b0;
      illegal = 1'b0;
      case (op_r)
         3'd0: ubit = and_o;
         3'd1: ubit = n_ab;
         3'd2: ubit = or_o;
         3'd3: ubit = nor_o;
`ifdef SERIAL_GATE_XOR_EN
         3'd4: ubit = xor_o;
         3'd5: ubit = xnor_o;
`else
         3'd4: illegal = 1'b1;
         3'd5: illegal = 1'b1;
`endif
         3'd6: ubit = n_a;
         default: illegal = 1'b1;
      endcase
   end

   // Next state, operand load strobe and status outputs
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end
         end
         S_RUN: begin
            busy_o = 1'b1;
            if (last) state_nxt = S_DONE;
         end
         S_DONE: begin
            done_o = 1'b1;
            if (start_i) begin
               state_nxt = S_RUN;
               load      = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, operand capture, bit shifting and result registration
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= '0;
         sr    <= '0;
         y_o   <= '0;
         err_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            a_r  <= a_i;
            b_r  <= b_i;
            op_r <= op_i;
            cnt  <= '0;
            sr   <= '0;
         end else if (state == S_RUN) begin
            sr <= full[WIDTH-1:1];
            if (last) begin
               // Final bit lands directly in y_o so it is valid in the done cycle
               cnt   <= '0;
               y_o   <= illegal ? '0 : full;
               err_o <= illegal;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

endmodule
